// File: rtl/kbd_mouse_pkg.sv
// Shared encodings for the keyboard/mouse byte stream coming from the SPI user-I/O receiver.
package kbd_mouse_pkg;

   localparam int KM_DATA_W = 8;

   typedef enum logic [1:0] {
      KMT_MOUSE_X = 2'd0,
      KMT_MOUSE_Y = 2'd1,
      KMT_KEY     = 2'd2,
      KMT_OSD     = 2'd3
   } kbd_mouse_type_t;

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through keycode FIFO; pointers carry one extra wrap bit to tell full from empty.
module kbd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           dout_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             pop_ok;
   logic             push_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Head is forced to zero while empty so the output has a defined reset value.
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/kbd_mouse_router.sv
// Turns the keyboard/mouse byte stream into mouse position counters, button state,
// a buffered keycode queue and an OSD keycode strobe.
module kbd_mouse_router
   import kbd_mouse_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk_sys,
   input  logic                       reset,
   input  logic                       kbd_mouse_strobe,
   input  logic [1:0]                 kbd_mouse_type,
   input  logic [7:0]                 kbd_mouse_data,
   input  logic [2:0]                 mouse_buttons,
   output logic [15:0]                mouse_dat,
   output logic [2:0]                 mouse_btn,
   output logic                       kbd_valid,
   output logic [7:0]                 kbd_code,
   input  logic                       kbd_ack,
   output logic [$clog2(DEPTH):0]     kbd_level,
   output logic                       kbd_overflow,
   input  logic                       ovf_clr,
   output logic                       osd_strobe,
   output logic [7:0]                 osd_code
);

   kbd_mouse_type_t         type_w;
   logic                    x_stb, y_stb, key_stb, osd_stb;
   logic                    fifo_empty, fifo_full, pop_ok, drop;
   logic signed [7:0]       delta_w;
   logic signed [7:0]       xcount_q, xcount_d;
   logic signed [7:0]       ycount_q, ycount_d;
   logic [KM_DATA_W-1:0]    osd_code_q, osd_code_d;
   logic                    osd_strobe_q;
   logic [2:0]              mouse_btn_q;
   logic                    ovf_q, ovf_d;

   assign type_w  = kbd_mouse_type_t'(kbd_mouse_type);
   assign x_stb   = kbd_mouse_strobe && (type_w == KMT_MOUSE_X);
   assign y_stb   = kbd_mouse_strobe && (type_w == KMT_MOUSE_Y);
   assign key_stb = kbd_mouse_strobe && (type_w == KMT_KEY);
   assign osd_stb = kbd_mouse_strobe && (type_w == KMT_OSD);
   assign delta_w = signed'(kbd_mouse_data);

   assign pop_ok  = kbd_ack && kbd_valid;
   assign drop    = key_stb && fifo_full && !pop_ok;

   kbd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (KM_DATA_W)
   ) u_fifo (
      .clk_i   (clk_sys),
      .rst_i   (reset),
      .push_i  (key_stb),
      .din_i   (kbd_mouse_data),
      .pop_i   (kbd_ack),
      .dout_o  (kbd_code),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .level_o (kbd_level)
   );

   assign kbd_valid = !fifo_empty;

   // Counters wrap modulo 256 like the Amiga JOYxDAT counters; no saturation.
   always_comb begin
      xcount_d   = xcount_q;
      ycount_d   = ycount_q;
      osd_code_d = osd_code_q;
      if (x_stb)   xcount_d   = xcount_q + delta_w;
      if (y_stb)   ycount_d   = ycount_q + delta_w;
      if (osd_stb) osd_code_d = kbd_mouse_data;
      // A new drop outranks a clear in the same cycle.
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
      else              ovf_d = ovf_q;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         xcount_q     <= '0;
         ycount_q     <= '0;
         osd_code_q   <= '0;
         osd_strobe_q <= 1'b0;
         mouse_btn_q  <= '0;
         ovf_q        <= 1'b0;
      end else begin
         xcount_q     <= xcount_d;
         ycount_q     <= ycount_d;
         osd_code_q   <= osd_code_d;
         osd_strobe_q <= osd_stb;
         mouse_btn_q  <= mouse_buttons;
         ovf_q        <= ovf_d;
      end
   end

   assign mouse_dat    = {ycount_q, xcount_q};
   assign mouse_btn    = mouse_btn_q;
   assign kbd_overflow = ovf_q;
   assign osd_strobe   = osd_strobe_q;
   assign osd_code     = osd_code_q;

endmodule

// File: tb/tb_kbd_mouse_router.sv
// Directed bench for kbd_mouse_router: mouse accumulation, keycode FIFO, overflow and OSD strobe.
module tb_kbd_mouse_router;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk_sys = 1'b0;
   logic          reset   = 1'b1;
   logic          kbd_mouse_strobe = 1'b0;
   logic [1:0]    kbd_mouse_type   = 2'd0;
   logic [7:0]    kbd_mouse_data   = 8'h00;
   logic [2:0]    mouse_buttons    = 3'b000;
   logic [15:0]   mouse_dat;
   logic [2:0]    mouse_btn;
   logic          kbd_valid;
   logic [7:0]    kbd_code;
   logic          kbd_ack = 1'b0;
   logic [LW-1:0] kbd_level;
   logic          kbd_overflow;
   logic          ovf_clr = 1'b0;
   logic          osd_strobe;
   logic [7:0]    osd_code;

   int n_checks = 0;
   int n_pass   = 0;

   kbd_mouse_router #(.DEPTH(DEPTH)) dut (
      .clk_sys          (clk_sys),
      .reset            (reset),
      .kbd_mouse_strobe (kbd_mouse_strobe),
      .kbd_mouse_type   (kbd_mouse_type),
      .kbd_mouse_data   (kbd_mouse_data),
      .mouse_buttons    (mouse_buttons),
      .mouse_dat        (mouse_dat),
      .mouse_btn        (mouse_btn),
      .kbd_valid        (kbd_valid),
      .kbd_code         (kbd_code),
      .kbd_ack          (kbd_ack),
      .kbd_level        (kbd_level),
      .kbd_overflow     (kbd_overflow),
      .ovf_clr          (ovf_clr),
      .osd_strobe       (osd_strobe),
      .osd_code         (osd_code)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
   endtask

   // One full clock: inputs driven at a falling edge are sampled at the next rising edge.
   task automatic step();
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   task automatic send(input logic [1:0] t, input logic [7:0] d, input logic ack);
      kbd_mouse_strobe = 1'b1;
      kbd_mouse_type   = t;
      kbd_mouse_data   = d;
      kbd_ack          = ack;
      step();
      kbd_mouse_strobe = 1'b0;
      kbd_ack          = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_mouse_dat"}, mouse_dat, 16'h0000);
      check({pfx, "_mouse_btn"}, 16'(mouse_btn), 16'h0);
      check({pfx, "_kbd_valid"}, 16'(kbd_valid), 16'h0);
      check({pfx, "_kbd_code"},  16'(kbd_code), 16'h00);
      check({pfx, "_kbd_level"}, 16'(kbd_level), 16'h0);
      check({pfx, "_overflow"},  16'(kbd_overflow), 16'h0);
      check({pfx, "_osd_strobe"}, 16'(osd_strobe), 16'h0);
      check({pfx, "_osd_code"},  16'(osd_code), 16'h00);
   endtask

   initial begin
      repeat (2) @(negedge clk_sys);
      check_reset_vals("rst");
      reset = 1'b0;
      step();

      // Mouse X accumulation, including a negative delta.
      send(2'd0, 8'h05, 1'b0);
      check("x_05", mouse_dat, 16'h0005);
      send(2'd0, 8'hFE, 1'b0);
      check("x_fe", mouse_dat, 16'h0003);

      // Mouse Y through the 0x7F/0x80 boundary; X untouched.
      send(2'd1, 8'h7F, 1'b0);
      check("y_7f", mouse_dat, 16'h7F03);
      send(2'd1, 8'h02, 1'b0);
      check("y_81", mouse_dat, 16'h8103);

      // X wraps to 0x00 and then below zero to 0xFF.
      send(2'd0, 8'hFD, 1'b0);
      check("x_wrap0", mouse_dat, 16'h8100);
      send(2'd0, 8'hFF, 1'b0);
      check("x_wrapff", mouse_dat, 16'h81FF);

      // Data without strobe is ignored.
      kbd_mouse_type = 2'd0;
      kbd_mouse_data = 8'h55;
      step();
      check("no_strobe", mouse_dat, 16'h81FF);

      mouse_buttons = 3'b101;
      step();
      check("btn", 16'(mouse_btn), 16'h5);

      // Three back-to-back keycodes, then drain.
      send(2'd2, 8'h45, 1'b0);
      check("k1_valid", 16'(kbd_valid), 16'h1);
      check("k1_code", 16'(kbd_code), 16'h45);
      send(2'd2, 8'h46, 1'b0);
      send(2'd2, 8'h47, 1'b0);
      check("k3_level", 16'(kbd_level), 16'd3);
      check("k3_head", 16'(kbd_code), 16'h45);
      kbd_ack = 1'b1;
      step();
      check("pop1_code", 16'(kbd_code), 16'h46);
      check("pop1_level", 16'(kbd_level), 16'd2);
      step();
      check("pop2_code", 16'(kbd_code), 16'h47);
      step();
      check("pop3_valid", 16'(kbd_valid), 16'h0);
      check("pop3_level", 16'(kbd_level), 16'd0);
      step();
      check("ack_empty_level", 16'(kbd_level), 16'd0);
      kbd_ack = 1'b0;

      // Push with ack on empty, then on non-empty.
      send(2'd2, 8'h10, 1'b1);
      check("pp_empty_level", 16'(kbd_level), 16'd1);
      check("pp_empty_code", 16'(kbd_code), 16'h10);
      send(2'd2, 8'h11, 1'b1);
      check("pp_ne_level", 16'(kbd_level), 16'd1);
      check("pp_ne_code", 16'(kbd_code), 16'h11);
      kbd_ack = 1'b1;
      step();
      kbd_ack = 1'b0;
      check("pp_drain", 16'(kbd_valid), 16'h0);

      // Fill, overflow, push-with-pop when full, clear priority.
      for (int i = 0; i < DEPTH; i++) send(2'd2, 8'(8'h60 + i), 1'b0);
      check("full_level", 16'(kbd_level), 16'(DEPTH));
      check("full_ovf0", 16'(kbd_overflow), 16'h0);
      send(2'd2, 8'h99, 1'b0);
      check("drop_ovf", 16'(kbd_overflow), 16'h1);
      check("drop_level", 16'(kbd_level), 16'(DEPTH));
      check("drop_head", 16'(kbd_code), 16'h60);
      send(2'd2, 8'hAA, 1'b1);
      check("fullpp_level", 16'(kbd_level), 16'(DEPTH));
      check("fullpp_head", 16'(kbd_code), 16'h61);
      check("fullpp_ovf", 16'(kbd_overflow), 16'h1);
      ovf_clr = 1'b1;
      send(2'd2, 8'hBB, 1'b0);
      check("set_beats_clr", 16'(kbd_overflow), 16'h1);
      step();
      ovf_clr = 1'b0;
      check("ovf_clr", 16'(kbd_overflow), 16'h0);
      kbd_ack = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
         check($sformatf("drain_%0d", i), 16'(kbd_code), 16'(8'h60 + i));
         step();
      end
      check("drain_aa", 16'(kbd_code), 16'hAA);
      step();
      kbd_ack = 1'b0;
      check("drain_empty", 16'(kbd_valid), 16'h0);

      // OSD strobe is a single-cycle pulse and bypasses the FIFO.
      send(2'd3, 8'h3A, 1'b0);
      check("osd_strobe1", 16'(osd_strobe), 16'h1);
      check("osd_code", 16'(osd_code), 16'h3A);
      check("osd_level", 16'(kbd_level), 16'd0);
      step();
      check("osd_strobe0", 16'(osd_strobe), 16'h0);
      check("osd_held", 16'(osd_code), 16'h3A);

      // Load state, then asynchronous reset between clock edges.
      for (int i = 0; i < 4; i++) send(2'd2, 8'(8'h20 + i), 1'b0);
      send(2'd0, 8'h35, 1'b0);
      send(2'd1, 8'h91, 1'b0);
      check("pre_rst_dat", mouse_dat, 16'h1234);
      check("pre_rst_level", 16'(kbd_level), 16'd4);
      #2 reset = 1'b1;
      #1 check_reset_vals("async");
      @(negedge clk_sys);
      reset = 1'b0;
      step();
      check("post_rst_level", 16'(kbd_level), 16'd0);
      check("post_rst_btn", 16'(mouse_btn), 16'h5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
